// File: rtl/hazard_unit.sv
// Hazard control for a 5-stage pipeline: load-use stalls, branch flushes and E-stage forwarding.
// Shadow E/M/W destination tags mean only decode-stage inputs plus PCSrcE are needed.
module hazard_unit #(
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] Rs1D,
    input  logic [ADDR_WIDTH-1:0] Rs2D,
    input  logic [ADDR_WIDTH-1:0] RdD,
    input  logic                  RegWriteD,
    input  logic                  LoadD,
    input  logic                  PCSrcE,
    output logic                  StallF,
    output logic                  StallD,
    output logic                  FlushD,
    output logic                  FlushE,
    output logic [1:0]            ForwardAE,
    output logic [1:0]            ForwardBE,
    output logic [CNT_WIDTH-1:0]  StallCount,
    output logic [CNT_WIDTH-1:0]  FlushCount
);

    logic [ADDR_WIDTH-1:0] rs1_e_reg, rs2_e_reg, rd_e_reg, rd_m_reg, rd_w_reg;
    logic                  regwrite_e_reg, load_e_reg, regwrite_m_reg, regwrite_w_reg;
    logic [CNT_WIDTH-1:0]  stall_count_reg, flush_count_reg;
    logic                  lw_stall;

    // The nearest older producer wins; x0 is never a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [ADDR_WIDTH-1:0] src);
        if (regwrite_m_reg && (rd_m_reg != '0) && (rd_m_reg == src))
            return 2'b10;
        else if (regwrite_w_reg && (rd_w_reg != '0) && (rd_w_reg == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lw_stall = load_e_reg && (rd_e_reg != '0) &&
                      ((rd_e_reg == Rs1D) || (rd_e_reg == Rs2D));

    assign StallF     = lw_stall && !PCSrcE;
    assign StallD     = lw_stall && !PCSrcE;
    assign FlushD     = PCSrcE;
    assign FlushE     = lw_stall || PCSrcE;
    assign ForwardAE  = fwd_sel(rs1_e_reg);
    assign ForwardBE  = fwd_sel(rs2_e_reg);
    assign StallCount = stall_count_reg;
    assign FlushCount = flush_count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rs1_e_reg      <= '0;
            rs2_e_reg      <= '0;
            rd_e_reg       <= '0;
            regwrite_e_reg <= 1'b0;
            load_e_reg     <= 1'b0;
            rd_m_reg       <= '0;
            regwrite_m_reg <= 1'b0;
            rd_w_reg       <= '0;
            regwrite_w_reg <= 1'b0;
        end else begin
            // A flushed E slot becomes a bubble that writes nothing.
            if (FlushE) begin
                rs1_e_reg      <= '0;
                rs2_e_reg      <= '0;
                rd_e_reg       <= '0;
                regwrite_e_reg <= 1'b0;
                load_e_reg     <= 1'b0;
            end else begin
                rs1_e_reg      <= Rs1D;
                rs2_e_reg      <= Rs2D;
                rd_e_reg       <= RdD;
                regwrite_e_reg <= RegWriteD;
                load_e_reg     <= LoadD;
            end
            rd_m_reg       <= rd_e_reg;
            regwrite_m_reg <= regwrite_e_reg;
            rd_w_reg       <= rd_m_reg;
            regwrite_w_reg <= regwrite_m_reg;
        end
    end

    // Event counters stick at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            if (StallD && (stall_count_reg != '1))
                stall_count_reg <= stall_count_reg + CNT_WIDTH'(1);
            if (PCSrcE && (flush_count_reg != '1))
                flush_count_reg <= flush_count_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: directed table, random run against an in-flight instruction history,
// counter saturation on a 4-bit counter instance, and asynchronous mid-run reset.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] rs1, rs2, rd;
    logic       rw, ld, pc;

    logic        stallf, stalld, flushd, flushe;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
    logic        stallf4, stalld4, flushd4, flushe4;
    logic [1:0]  fa4, fb4;
    logic [3:0]  sc4, fc4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .Rs1D(rs1), .Rs2D(rs2), .RdD(rd),
        .RegWriteD(rw), .LoadD(ld), .PCSrcE(pc),
        .StallF(stallf), .StallD(stalld), .FlushD(flushd), .FlushE(flushe),
        .ForwardAE(fa), .ForwardBE(fb), .StallCount(sc), .FlushCount(fc));

    hazard_unit #(.ADDR_WIDTH(5), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .Rs1D(rs1), .Rs2D(rs2), .RdD(rd),
        .RegWriteD(rw), .LoadD(ld), .PCSrcE(pc),
        .StallF(stallf4), .StallD(stalld4), .FlushD(flushd4), .FlushE(flushe4),
        .ForwardAE(fa4), .ForwardBE(fb4), .StallCount(sc4), .FlushCount(fc4));

    // Reference model: history of what entered E each cycle, newest first (0=E, 1=M, 2=W).
    typedef struct packed {
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld;
    } ins_t;

    ins_t   hist[$];
    longint m_stall, m_flush;
    logic   e_stall, e_flushd, e_flushe;
    logic [1:0] e_fa, e_fb;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       rw, ld, pc;
        logic       st, fd, fe;
        logic [1:0] fa, fb;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(int a, int b, int d, int w, int l, int p,
                                int st, int fd, int fe, int xa, int xb);
        vec_t v;
        v.rs1 = 5'(a); v.rs2 = 5'(b); v.rd = 5'(d);
        v.rw = 1'(w); v.ld = 1'(l); v.pc = 1'(p);
        v.st = 1'(st); v.fd = 1'(fd); v.fe = 1'(fe);
        v.fa = 2'(xa); v.fb = 2'(xb);
        return v;
    endfunction

    function automatic void model_clear();
        hist = {};
        repeat (3) hist.push_back('0);
        m_stall = 0;
        m_flush = 0;
    endfunction

    // Distance 1 to the producer means it sits in M, distance 2 means W.
    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (src == 0) return 2'b00;
        for (int age = 1; age <= 2; age++)
            if (hist[age].rw && hist[age].rd == src)
                return (age == 1) ? 2'b10 : 2'b01;
        return 2'b00;
    endfunction

    function automatic void model_eval();
        logic hit;
        hit = hist[0].ld && hist[0].rd != 0 && (hist[0].rd == rs1 || hist[0].rd == rs2);
        e_stall  = hit && !pc;
        e_flushd = pc;
        e_flushe = hit || pc;
        e_fa     = model_fwd(hist[0].rs1);
        e_fb     = model_fwd(hist[0].rs2);
    endfunction

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] a, b, d, input logic w, l, p);
        rs1 = a; rs2 = b; rd = d; rw = w; ld = l; pc = p;
    endtask

    // Moves the model across one rising edge using the pre-edge inputs.
    task automatic advance();
        ins_t cur;
        model_eval();
        cur = '{rs1: rs1, rs2: rs2, rd: rd, rw: rw, ld: ld};
        @(posedge clk);
        if (!rst_n) begin
            model_clear();
        end else begin
            if (e_stall) m_stall++;
            if (pc) m_flush++;
            hist.push_front(e_flushe ? ins_t'('0) : cur);
            void'(hist.pop_back());
        end
        #1;
    endtask

    task automatic check_model(input string tag);
        model_eval();
        chk({tag, ".StallF"}, stallf, e_stall);
        chk({tag, ".StallD"}, stalld, e_stall);
        chk({tag, ".FlushD"}, flushd, e_flushd);
        chk({tag, ".FlushE"}, flushe, e_flushe);
        chk({tag, ".ForwardAE"}, fa, e_fa);
        chk({tag, ".ForwardBE"}, fb, e_fb);
        chk({tag, ".StallCount"}, sc, sat(m_stall, 64'hFFFF_FFFF));
        chk({tag, ".FlushCount"}, fc, sat(m_flush, 64'hFFFF_FFFF));
        chk({tag, ".StallD4"}, stalld4, e_stall);
        chk({tag, ".FlushE4"}, flushe4, e_flushe);
        chk({tag, ".ForwardAE4"}, fa4, e_fa);
        chk({tag, ".ForwardBE4"}, fb4, e_fb);
        chk({tag, ".StallCount4"}, sc4, sat(m_stall, 15));
        chk({tag, ".FlushCount4"}, fc4, sat(m_flush, 15));
        $display("cycle %s rs1=%0d rs2=%0d rd=%0d rw=%0b ld=%0b pc=%0b -> st=%0b fe=%0b fa=%0b fb=%0b sc=%0d",
                 tag, rs1, rs2, rd, rw, ld, pc, stalld, flushe, fa, fb, sc);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".StallF"}, stallf, 0);
        chk({tag, ".StallD"}, stalld, 0);
        chk({tag, ".FlushD"}, flushd, 0);
        chk({tag, ".FlushE"}, flushe, 0);
        chk({tag, ".ForwardAE"}, fa, 0);
        chk({tag, ".ForwardBE"}, fb, 0);
        chk({tag, ".StallCount"}, sc, 0);
        chk({tag, ".FlushCount"}, fc, 0);
        $display("cycle %s rs1=%0d rs2=%0d rst_n=%0b -> all zero expected", tag, rs1, rs2, rst_n);
    endtask

    initial begin
        //              rs1 rs2 rd rw ld pc | st fd fe fa fb
        tbl[0]  = mk(0, 0, 5, 1, 0, 0,   0, 0, 0, 0, 0);  // add x5
        tbl[1]  = mk(5, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // use x5 as rs1
        tbl[2]  = mk(0, 5, 0, 0, 0, 0,   0, 0, 0, 2, 0);  // E=rs1 user, M=add x5
        tbl[3]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);  // E=rs2 user, W=add x5
        tbl[4]  = mk(0, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0);  // write x0
        tbl[5]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 0);  // M=x0 writer must not forward
        tbl[7]  = mk(0, 0, 7, 1, 0, 0,   0, 0, 0, 0, 0);
        tbl[8]  = mk(7, 7, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 2, 2);  // M wins over W
        tbl[10] = mk(0, 0, 3, 1, 1, 0,   0, 0, 0, 0, 0);  // lw x3
        tbl[11] = mk(0, 3, 0, 0, 0, 0,   1, 0, 1, 0, 0);  // load-use stall
        tbl[12] = mk(0, 3, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // held, E is bubble
        tbl[13] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1);  // load result from W
        tbl[14] = mk(0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0);  // branch taken
        tbl[15] = mk(0, 0, 4, 1, 1, 0,   0, 0, 0, 0, 0);  // lw x4
        tbl[16] = mk(4, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0);  // branch beats load-use
        tbl[17] = mk(0, 0, 0, 1, 1, 0,   0, 0, 0, 0, 0);  // lw x0
        tbl[18] = mk(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0);  // x0 load never stalls

        model_clear();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);

        // Reset held with random sources and destinations, no branch.
        for (int i = 0; i < 4; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 0);
            @(negedge clk);
            check_zero($sformatf("reset%0d", i));
            advance();
        end
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(5'($urandom), 5'($urandom), 5'($urandom), 0, 0, 0);
            @(negedge clk);
            check_zero($sformatf("release%0d", i));
            advance();
        end

        foreach (tbl[i]) begin
            drive(tbl[i].rs1, tbl[i].rs2, tbl[i].rd, tbl[i].rw, tbl[i].ld, tbl[i].pc);
            @(negedge clk);
            chk($sformatf("vec%0d.StallF", i), stallf, tbl[i].st);
            chk($sformatf("vec%0d.StallD", i), stalld, tbl[i].st);
            chk($sformatf("vec%0d.FlushD", i), flushd, tbl[i].fd);
            chk($sformatf("vec%0d.FlushE", i), flushe, tbl[i].fe);
            chk($sformatf("vec%0d.ForwardAE", i), fa, tbl[i].fa);
            chk($sformatf("vec%0d.ForwardBE", i), fb, tbl[i].fb);
            $display("vec %0d rs1=%0d rs2=%0d rd=%0d rw=%0b ld=%0b pc=%0b -> st=%0b fd=%0b fe=%0b fa=%0b fb=%0b",
                     i, rs1, rs2, rd, rw, ld, pc, stalld, flushd, flushe, fa, fb);
            advance();
        end
        chk("table.StallCount", sc, 1);
        chk("table.FlushCount", fc, 2);

        // Random traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 300; i++) begin
            drive(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 7) == 0));
            @(negedge clk);
            check_model($sformatf("rnd%0d", i));
            advance();
        end

        // Fresh counters, then twenty load-use pairs.
        @(negedge clk);
        #2 rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        advance();
        @(negedge clk);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 0, 3, 1, 1, 0);
            @(negedge clk);
            check_model($sformatf("sat%0d.lw", i));
            advance();
            drive(0, 3, 0, 0, 0, 0);
            @(negedge clk);
            check_model($sformatf("sat%0d.use", i));
            advance();
            @(negedge clk);
            check_model($sformatf("sat%0d.held", i));
            advance();
        end
        chk("sat.StallCount32", sc, 20);
        chk("sat.StallCount4", sc4, 15);
        chk("sat.FlushCount4", fc4, 0);

        // Asynchronous reset between edges must drop forwarding at once.
        drive(0, 0, 5, 1, 0, 0);
        advance();
        drive(5, 0, 0, 0, 0, 0);
        advance();
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("midrst.before.ForwardAE", fa, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst.ForwardAE", fa, 0);
        chk("midrst.StallCount", sc, 0);
        chk("midrst.StallCount4", sc4, 0);
        $display("midrst rst_n=%0b -> fa=%0b sc=%0d", rst_n, fa, sc);
        model_clear();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_unit.md
Name: hazard_unit

Overview:
- Consumer-side control for the decode-to-execute pipeline register: reads decode-stage source/destination info and drives stall, flush and forwarding back to the pipeline.
- Keeps its own shadow pipeline of E/M/W destination tags, so forwarding and load-use detection need only D-stage inputs plus the branch decision.
- Sits beside the D/E and E/M registers.
- Also exposes saturating stall and flush event counters for performance debug.

Parameters:
- ADDR_WIDTH, 5, register-file address width.
- CNT_WIDTH, 32, width of each performance counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Rs1D  input  ADDR_WIDTH  source 1 of the decode-stage instruction.
- Rs2D  input  ADDR_WIDTH  source 2 of the decode-stage instruction.
- RdD  input  ADDR_WIDTH  destination of the decode-stage instruction.
- RegWriteD  input  1  decode-stage instruction writes the register file.
- LoadD  input  1  decode-stage instruction is a load (result comes from memory).
- PCSrcE  input  1  taken branch/jump resolved in E.
- StallF  output  1  hold PC register.
- StallD  output  1  hold F/D register.
- FlushD  output  1  clear F/D register.
- FlushE  output  1  clear D/E register.
- ForwardAE  output  2  ALU operand A select: 00 = RD1E, 10 = ALUResultM, 01 = ResultW.
- ForwardBE  output  2  ALU operand B select, same encoding.
- StallCount  output  CNT_WIDTH  cycles with a load-use stall.
- FlushCount  output  CNT_WIDTH  cycles with PCSrcE high.

Behaviour:
- Reset is asynchronous and active-low (rst_n); clk is the only clock.
- Reset clears every shadow register and both counters to 0. With PCSrcE = 0 during and after reset, all outputs are 0.
- Shadow registers, updated on each rising clk edge:
  - E slot: rs1E, rs2E, rdE, regwriteE, loadE.
  - M slot: rdM, regwriteM.
  - W slot: rdW, regwriteW.
- E slot update:
  - If FlushE is high, the E slot loads all zeros (a bubble).
  - Otherwise it loads Rs1D, Rs2D, RdD, RegWriteD, LoadD.
- The M slot always loads from the E slot and the W slot always loads from the M slot. These stages never stall.
- Load-use detect: lwStall = loadE & (rdE != 0) & ((rdE == Rs1D) | (rdE == Rs2D)). The outputs below are combinational from the current shadow state and D inputs.
  - StallF = StallD = lwStall & ~PCSrcE. PCSrcE has priority in the simultaneous case (illegal in a correct pipeline, but defined).
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Forwarding for operand A:
  - ForwardAE = 10 if regwriteM & rdM != 0 & rdM == rs1E.
  - Else 01 if regwriteW & rdW != 0 & rdW == rs1E.
  - Else 00.
  - M has priority over W when both match.
- ForwardBE follows the same rules using rs2E.
- Register x0 never forwards and never causes a stall.
- Stall bubble: after a load-use stall the E slot holds a bubble for one cycle and the load advances to M. On the next cycle lwStall is therefore 0, giving exactly one stall cycle per load-use pair. The stalled D instruction enters E one cycle later.
- Counters:
  - StallCount increments on each clock edge where StallD is 1.
  - FlushCount increments on each clock edge where PCSrcE is 1.
  - Both saturate at all-ones and never wrap.
- Reset mid-operation asynchronously clears the shadow pipeline and counters. Forwarding outputs go to 00 immediately, without waiting for a clock edge.

Test Plan:
- Reset: hold rst_n = 0 with random inputs, PCSrcE = 0 → all outputs 0, counters 0. Release → outputs stay 0 while RegWriteD = 0.
- EX-to-EX forward: issue add x5 (RdD = 5, RegWriteD = 1), then Rs1D = 5 on the next cycle → ForwardAE = 10 one cycle later; the cycle after that, a consumer with Rs2D = 5 gets ForwardBE = 01.
- x0 and priority: writes to x0 never forward. Back-to-back writes to x7 followed by a consumer of x7 → ForwardAE = 10 (M wins over W).
- Load-use: lw x3 (LoadD = 1, RdD = 3), then Rs2D = 3 → StallF = StallD = FlushE = 1 for exactly one cycle, then ForwardBE = 01. StallCount = 1.
- Branch taken: PCSrcE = 1 for one cycle → FlushD = FlushE = 1, StallF = 0, FlushCount = 1. PCSrcE together with lwStall → StallD = 0, FlushE = 1.
- Saturation: with CNT_WIDTH = 4, hold a load-use condition for 20 stall events → StallCount stops at 15.
